// File: rtl/fir_fifo_writer.sv
// Write-side producer for the dual-clock sample FIFO: a 2-entry skid buffer
// between the FIR output stream and the FIFO write port, with run/drain control.
module fir_fifo_writer #(
    parameter int unsigned DWIDTH      = 16,
    parameter int unsigned CWIDTH      = 16,
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic              wr_clk,
    input  logic              areset_n_wr,
    input  logic              enable,
    input  logic              drop_mode,
    input  logic              clr,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              fifo_full,
    output logic              fifo_write,
    output logic [DWIDTH-1:0] fifo_data,
    output logic              busy,
    output logic [CWIDTH-1:0] samples_written,
    output logic [CWIDTH-1:0] overflow_cnt,
    output logic              stall_err
);

    localparam int unsigned SWIDTH = $clog2(STALL_LIMIT + 1);
    localparam logic [SWIDTH-1:0] STALL_MAX = SWIDTH'(STALL_LIMIT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        count_q, count_d;
    logic [DWIDTH-1:0] entry0_q, entry0_d;
    logic [DWIDTH-1:0] entry1_q, entry1_d;
    logic [CWIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [CWIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [SWIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic              stall_err_q, stall_err_d;

    logic ready_c;
    logic pop_c;
    logic push_c;
    logic drop_c;
    logic stall_c;

    // Handshake decode; s_ready depends only on registered state and the mode pin
    always_comb begin
        ready_c = (state_q == ST_RUN) && (drop_mode || (count_q != 2'd2));
        pop_c   = (count_q != 2'd0) && !fifo_full && (state_q != ST_IDLE);
        push_c  = s_valid && ready_c && (count_q != 2'd2);
        drop_c  = s_valid && ready_c && (count_q == 2'd2);
        stall_c = (count_q != 2'd0) && fifo_full && (state_q != ST_IDLE);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (count_q == 2'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Skid buffer: pop shifts entry1 down, push lands in the first free slot after the pop
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q + 2'(push_c) - 2'(pop_c);
        if (pop_c) begin
            entry0_d = entry1_q;
        end
        if (push_c) begin
            if (count_d == 2'd1) begin
                entry0_d = s_data;
            end else begin
                entry1_d = s_data;
            end
        end
    end

    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        stall_cnt_d = stall_cnt_q;
        stall_err_d = stall_err_q;
        if (clr) begin
            wr_cnt_d    = '0;
            ovf_cnt_d   = '0;
            stall_cnt_d = '0;
            stall_err_d = 1'b0;
        end else begin
            if (pop_c) begin
                wr_cnt_d = wr_cnt_q + CWIDTH'(1);
            end
            if (drop_c && (ovf_cnt_q != {CWIDTH{1'b1}})) begin
                ovf_cnt_d = ovf_cnt_q + CWIDTH'(1);
            end
            if (stall_c) begin
                if (stall_cnt_q != STALL_MAX) begin
                    stall_cnt_d = stall_cnt_q + SWIDTH'(1);
                end
            end else begin
                stall_cnt_d = '0;
            end
            if (stall_c && (stall_cnt_d == STALL_MAX)) begin
                stall_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wr_clk or negedge areset_n_wr) begin
        if (!areset_n_wr) begin
            state_q     <= ST_IDLE;
            count_q     <= 2'd0;
            entry0_q    <= '0;
            entry1_q    <= '0;
            wr_cnt_q    <= '0;
            ovf_cnt_q   <= '0;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            entry0_q    <= entry0_d;
            entry1_q    <= entry1_d;
            wr_cnt_q    <= wr_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign s_ready         = ready_c;
    assign fifo_write      = pop_c;
    assign fifo_data       = entry0_q;
    assign busy            = (state_q != ST_IDLE);
    assign samples_written = wr_cnt_q;
    assign overflow_cnt    = ovf_cnt_q;
    assign stall_err       = stall_err_q;

endmodule

// File: tb/tb_fir_fifo_writer.sv
// Bench for fir_fifo_writer: directed vector table, corner sequences and a
// random phase, all checked against a queue-based model of the writer.
module tb_fir_fifo_writer;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned SL = 4;

    logic          wr_clk      = 1'b0;
    logic          areset_n_wr = 1'b1;
    logic          enable      = 1'b0;
    logic          drop_mode   = 1'b0;
    logic          clr         = 1'b0;
    logic [DW-1:0] s_data      = '0;
    logic          s_valid     = 1'b0;
    logic          s_ready;
    logic          fifo_full   = 1'b0;
    logic          fifo_write;
    logic [DW-1:0] fifo_data;
    logic          busy;
    logic [CW-1:0] samples_written;
    logic [CW-1:0] overflow_cnt;
    logic          stall_err;

    fir_fifo_writer #(.DWIDTH(DW), .CWIDTH(CW), .STALL_LIMIT(SL)) dut (
        .wr_clk(wr_clk), .areset_n_wr(areset_n_wr), .enable(enable),
        .drop_mode(drop_mode), .clr(clr), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .fifo_full(fifo_full), .fifo_write(fifo_write),
        .fifo_data(fifo_data), .busy(busy), .samples_written(samples_written),
        .overflow_cnt(overflow_cnt), .stall_err(stall_err)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        bit          en, dm, cl, v;
        logic [15:0] d;
        bit          f;
        bit          e_ready, e_write;
        logic [15:0] e_data;
        bit          e_busy;
    } vec_t;

    // Reference model: mode 0=idle 1=run 2=drain, buffer as a queue
    logic [15:0] mq[$];
    int          mst;
    int unsigned m_wr, m_ovf, m_stall;
    bit          m_err;
    int          n_err = 0;
    int          n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mst = 0; m_wr = 0; m_ovf = 0; m_stall = 0; m_err = 0;
    endtask

    task automatic drive(input bit en, dm, cl, v, input logic [15:0] d, input bit f);
        enable = en; drop_mode = dm; clr = cl; s_valid = v; s_data = d; fifo_full = f;
    endtask

    task automatic check_model();
        bit er, ew;
        er = (mst == 1) && (drop_mode || mq.size() != 2);
        ew = (mq.size() != 0) && !fifo_full && (mst != 0);
        chk("s_ready", 32'(s_ready), 32'(er));
        chk("fifo_write", 32'(fifo_write), 32'(ew));
        if (mq.size() != 0) chk("fifo_data", 32'(fifo_data), 32'(mq[0]));
        chk("busy", 32'(busy), 32'(mst != 0));
        chk("samples_written", 32'(samples_written), m_wr);
        chk("overflow_cnt", 32'(overflow_cnt), m_ovf);
        chk("stall_err", 32'(stall_err), 32'(m_err));
    endtask

    // Apply the cycle's effect to the model, then move to just after the next edge
    task automatic advance();
        int sz;
        bit er, pop, push, drop;
        sz   = mq.size();
        er   = (mst == 1) && (drop_mode || sz != 2);
        pop  = (sz != 0) && !fifo_full && (mst != 0);
        push = s_valid && er && (sz != 2);
        drop = s_valid && er && (sz == 2);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(s_data);
        if (clr) begin
            m_wr = 0; m_ovf = 0; m_stall = 0; m_err = 0;
        end else begin
            if (pop) m_wr = (m_wr + 1) % 65536;
            if (drop && m_ovf < 65535) m_ovf++;
            if (sz != 0 && fifo_full && mst != 0) m_stall++;
            else m_stall = 0;
            if (m_stall >= SL) m_err = 1;
        end
        case (mst)
            0:       if (enable) mst = 1;
            1:       if (!enable) mst = 2;
            2:       if (enable) mst = 1; else if (sz == 0) mst = 0;
            default: mst = 0;
        endcase
        @(posedge wr_clk);
        #1;
    endtask

    task automatic step(input bit en, dm, cl, v, input logic [15:0] d, input bit f);
        drive(en, dm, cl, v, d, f);
        #2;
        check_model();
        advance();
    endtask

    function automatic vec_t mk(input bit en, dm, cl, v, input logic [15:0] d, input bit f,
                                input bit er, ew, input logic [15:0] ed, input bit eb);
        vec_t t;
        t.en = en; t.dm = dm; t.cl = cl; t.v = v; t.d = d; t.f = f;
        t.e_ready = er; t.e_write = ew; t.e_data = ed; t.e_busy = eb;
        return t;
    endfunction

    initial begin
        vec_t tv[$];
        bit   rv, rf, rdm;

        model_reset();
        #1 areset_n_wr = 1'b0;
        #1;
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_fifo_write", 32'(fifo_write), 0);
        chk("rst_fifo_data", 32'(fifo_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_samples_written", 32'(samples_written), 0);
        chk("rst_overflow_cnt", 32'(overflow_cnt), 0);
        chk("rst_stall_err", 32'(stall_err), 0);
        #10 areset_n_wr = 1'b1;
        @(posedge wr_clk);
        #1;

        // Back-to-back burst, then blocking backpressure
        tv.push_back(mk(1,0,0,0,16'h0000,0, 0,0,16'h0000,0));
        tv.push_back(mk(1,0,0,1,16'h0001,0, 1,0,16'h0000,1));
        tv.push_back(mk(1,0,0,1,16'h0002,0, 1,1,16'h0001,1));
        tv.push_back(mk(1,0,0,1,16'h0003,0, 1,1,16'h0002,1));
        tv.push_back(mk(1,0,0,1,16'h0004,0, 1,1,16'h0003,1));
        tv.push_back(mk(1,0,0,1,16'h0005,0, 1,1,16'h0004,1));
        tv.push_back(mk(1,0,0,0,16'h0000,0, 1,1,16'h0005,1));
        tv.push_back(mk(1,0,0,0,16'h0000,0, 1,0,16'h0000,1));
        tv.push_back(mk(1,0,0,1,16'h000A,1, 1,0,16'h0000,1));
        tv.push_back(mk(1,0,0,1,16'h000B,1, 1,0,16'h0000,1));
        tv.push_back(mk(1,0,0,1,16'h000C,1, 0,0,16'h0000,1));
        tv.push_back(mk(1,0,0,1,16'h000C,0, 0,1,16'h000A,1));
        tv.push_back(mk(1,0,0,1,16'h000C,0, 1,1,16'h000B,1));
        tv.push_back(mk(1,0,0,0,16'h0000,0, 1,1,16'h000C,1));
        tv.push_back(mk(1,0,0,0,16'h0000,0, 1,0,16'h0000,1));
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].en, tv[i].dm, tv[i].cl, tv[i].v, tv[i].d, tv[i].f);
            #2;
            chk("tbl_s_ready", 32'(s_ready), 32'(tv[i].e_ready));
            chk("tbl_fifo_write", 32'(fifo_write), 32'(tv[i].e_write));
            if (tv[i].e_write) chk("tbl_fifo_data", 32'(fifo_data), 32'(tv[i].e_data));
            chk("tbl_busy", 32'(busy), 32'(tv[i].e_busy));
            if (i == 7) chk("burst_samples_written", 32'(samples_written), 5);
            check_model();
            advance();
        end
        chk("tbl_samples_written", 32'(samples_written), 8);

        // Drop mode with the FIFO full: newest samples discarded
        step(1,1,0,1,16'h0010,1);
        step(1,1,0,1,16'h0011,1);
        step(1,1,0,1,16'h0012,1);
        step(1,1,0,1,16'h0013,1);
        chk("drop_overflow_cnt", 32'(overflow_cnt), 2);
        chk("drop_head", 32'(fifo_data), 32'h10);
        drive(1,1,0,0,16'h0000,0);
        #2;
        chk("drop_write0", 32'(fifo_write), 1);
        chk("drop_data0", 32'(fifo_data), 32'h10);
        check_model();
        advance();
        drive(1,1,0,0,16'h0000,0);
        #2;
        chk("drop_data1", 32'(fifo_data), 32'h11);
        check_model();
        advance();
        drive(1,1,0,0,16'h0000,0);
        #2;
        chk("drop_no_third", 32'(fifo_write), 0);
        check_model();
        advance();

        // Drain with two buffered entries
        step(1,0,0,1,16'h0021,1);
        step(1,0,0,1,16'h0022,1);
        step(0,0,0,0,16'h0000,0);
        chk("drain_s_ready", 32'(s_ready), 0);
        step(0,0,0,0,16'h0000,0);
        chk("drain_busy_empty", 32'(busy), 1);
        step(0,0,0,0,16'h0000,0);
        chk("drain_busy_idle", 32'(busy), 0);
        chk("drain_samples_written", 32'(samples_written), 12);

        // Stall watchdog at its limit, sticky until clr
        step(1,0,1,0,16'h0000,0);
        step(1,0,0,1,16'h0055,1);
        for (int k = 0; k < 4; k++) begin
            step(1,0,0,0,16'h0000,1);
            if (k == 2) chk("stall_below_limit", 32'(stall_err), 0);
        end
        chk("stall_set", 32'(stall_err), 1);
        step(1,0,0,0,16'h0000,0);
        chk("stall_sticky", 32'(stall_err), 1);
        step(1,0,1,0,16'h0000,0);
        chk("stall_clr", 32'(stall_err), 0);

        // Asynchronous reset mid-burst with a full buffer
        step(1,0,0,1,16'h0061,1);
        step(1,0,0,1,16'h0062,1);
        drive(1,0,0,1,16'h0063,0);
        #2;
        chk("pre_rst_write", 32'(fifo_write), 1);
        areset_n_wr = 1'b0;
        #1;
        chk("arst_fifo_write", 32'(fifo_write), 0);
        chk("arst_s_ready", 32'(s_ready), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_samples_written", 32'(samples_written), 0);
        chk("arst_overflow_cnt", 32'(overflow_cnt), 0);
        chk("arst_stall_err", 32'(stall_err), 0);
        chk("arst_fifo_data", 32'(fifo_data), 0);
        model_reset();
        @(posedge wr_clk);
        #1;
        drive(0,0,0,0,16'h0000,0);
        areset_n_wr = 1'b1;
        step(0,0,0,0,16'h0000,0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            rdm = ((i / 60) % 2) == 1;
            rv  = ($urandom % 4) != 0;
            if (((i / 25) % 4) == 3) rf = ($urandom % 5) != 0;
            else rf = ($urandom % 3) == 0;
            step(($urandom % 12) != 0, rdm, ($urandom % 50) == 0, rv, 16'($urandom), rf);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
